// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and pixel types shared by the VGA source
package vga_pkg;
  localparam int COORD_W  = 10;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/vga_sync_gen_axis_counter.sv
// vga_axis_counter: mod-N counter that advances on en_i and flags the wrapping step
module vga_axis_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap_o = en_i && cnt_q == W'(N - 1);
  always_comb cnt_d = wrap_o ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster/sync generator driving the ADV7123 DAC with 1-pixel aligned RGB and sync
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [vga_pkg::COORD_W-1:0]  h_counter,
  output logic [vga_pkg::COORD_W-1:0]  v_counter,
  output logic                         pixel_tick,
  output logic                         frame_start,
  input  logic [7:0]                   r_in,
  input  logic [7:0]                   g_in,
  input  logic [7:0]                   b_in,
  output logic [7:0]                   vga_r,
  output logic [7:0]                   vga_g,
  output logic [7:0]                   vga_b,
  output logic                         vga_hs,
  output logic                         vga_vs,
  output logic                         vga_blank_n,
  output logic                         vga_sync_n,
  output logic                         vga_clk
);
  import vga_pkg::*;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int HT_N  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT_N  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COORD_W-1:0] H_VIS = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_LO = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_HI = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_LO = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_HI = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  logic [DIV_W-1:0] div_q, div_d;
  logic h_wrap, v_wrap, active, hs_n, vs_n;
  rgb_t rgb_q, rgb_d;
  logic hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  assign pixel_tick = div_q == DIV_LAST;
  assign vga_clk    = div_q >= DIV_HALF;
  vga_axis_counter #(.N(HT_N), .W(COORD_W)) u_h (
    .clk(clk), .reset(reset), .en_i(pixel_tick), .cnt_o(h_counter), .wrap_o(h_wrap)
  );
  vga_axis_counter #(.N(VT_N), .W(COORD_W)) u_v (
    .clk(clk), .reset(reset), .en_i(h_wrap), .cnt_o(v_counter), .wrap_o(v_wrap)
  );
  assign frame_start = v_wrap;
  assign active = h_counter < H_VIS && v_counter < V_VIS;
  assign hs_n   = !(h_counter >= HS_LO && h_counter < HS_HI);
  assign vs_n   = !(v_counter >= VS_LO && v_counter < VS_HI);
  // RGB and sync for pixel (h,v) are captured on the same tick that leaves (h,v), so they never skew
  always_comb begin
    div_d   = pixel_tick ? '0 : div_q + DIV_W'(1);
    rgb_d   = !pixel_tick ? rgb_q : active ? rgb_t'({r_in, g_in, b_in}) : '0;
    hs_d    = pixel_tick ? hs_n : hs_q;
    vs_d    = pixel_tick ? vs_n : vs_q;
    blank_d = pixel_tick ? active : blank_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
    end
  end
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;
  assign vga_sync_n  = 1'b0;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: time-based raster model checks on three instances (two small geometries, one full 640x480)
module tb_vga_sync_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [3];
  logic [7:0] rr, rg, rb;
  int errors = 0;
  int checks = 0;
  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  always @(negedge clk) begin
    rr <= 8'($urandom);
    rg <= 8'($urandom);
    rb <= 8'($urandom);
  end
  // u[0]: small raster, div 2; u[1]: small raster, div 4; u[2]: full 640x480, div 2, h/v renderer
  for (genvar i = 0; i < 3; i++) begin : u
    localparam int D   = i == 1 ? 4 : 2;
    localparam int HA  = i == 2 ? 640 : 8;
    localparam int HFP = i == 2 ? 16 : 2;
    localparam int HSW = i == 2 ? 96 : 3;
    localparam int HBP = i == 2 ? 48 : 2;
    localparam int VA  = i == 2 ? 480 : 6;
    localparam int VFP = i == 2 ? 10 : 2;
    localparam int VSW = 2;
    localparam int VBP = i == 2 ? 33 : 3;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int F   = HT * VT;
    logic [9:0] h, v;
    logic [7:0] ri, gi, bi, vr, vg, vb;
    logic tick, fs, hs, vs, bn, sn, vc;
    int n = 0;
    bit ok = 1'b0;
    logic [23:0] cap;
    int k, p, q, qh, qv, dv, er;
    logic act;
    logic [3:0] es;
    assign ri = i == 2 ? h[7:0] : rr;
    assign gi = i == 2 ? v[7:0] : rg;
    assign bi = i == 2 ? 8'hFF : rb;
    vga_sync_gen #(
      .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
      .clk(clk), .reset(rst[i]), .h_counter(h), .v_counter(v), .pixel_tick(tick),
      .frame_start(fs), .r_in(ri), .g_in(gi), .b_in(bi), .vga_r(vr), .vga_g(vg),
      .vga_b(vb), .vga_hs(hs), .vga_vs(vs), .vga_blank_n(bn), .vga_sync_n(sn), .vga_clk(vc)
    );
    // n = clocks since the last reset edge; the pixel-k tick closes at clock n = k*D + D-1
    always @(posedge clk) begin
      if (rst[i]) begin
        n  <= 0;
        ok <= 1'b1;
      end else if (ok) begin
        if (n % D == D - 1) cap <= {ri, gi, bi};
        n <= n + 1;
      end
    end
    always @(negedge clk) if (ok) begin
      k  = n / D;
      p  = k % F;
      dv = n % D;
      check($sformatf("u%0d.hv", i), int'({h, v}), ((p % HT) << 10) | (p / HT));
      check($sformatf("u%0d.strobe", i), int'({tick, fs, vc}),
            ((dv == D - 1) ? 4 : 0) | ((dv == D - 1 && p == F - 1) ? 2 : 0) | ((dv >= D / 2) ? 1 : 0));
      if (k == 0) begin
        er = 0;
        es = 4'b1100;
      end else begin
        q   = (k - 1) % F;
        qh  = q % HT;
        qv  = q / HT;
        act = qh < HA && qv < VA;
        er  = act ? int'(cap) : 0;
        es  = {!(qh >= HA + HFP && qh < HA + HFP + HSW), !(qv >= VA + VFP && qv < VA + VFP + VSW), act, 1'b0};
      end
      check($sformatf("u%0d.rgb", i), int'({vr, vg, vb}), er);
      check($sformatf("u%0d.sync", i), int'({hs, vs, bn, sn}), int'(es));
    end
  end
  typedef struct {
    int h;
    int v;
    logic [23:0] rgb;
    logic [2:0] sync;
  } vec_t;
  vec_t tbl [10];
  task automatic wait_n(input int t);
    for (int g = 0; g < 200000 && u[2].n < t; g++) @(negedge clk);
    check("wait_n", u[2].n, t);
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, ".hv"}, int'({u[2].h, u[2].v}), 0);
    check({tag, ".strobe"}, int'({u[2].tick, u[2].fs, u[2].vc}), 0);
    check({tag, ".rgb"}, int'({u[2].vr, u[2].vg, u[2].vb}), 0);
    check({tag, ".sync"}, int'({u[2].hs, u[2].vs, u[2].bn, u[2].sn}), 4'b1100);
  endtask
  int lo, vis, first, hmax, vmax, nfs, n1, n2;
  initial begin
    tbl = '{
      '{0,   0, 24'h0000FF, 3'b111},
      '{639, 0, 24'h7F00FF, 3'b111},
      '{640, 0, 24'h000000, 3'b110},
      '{655, 0, 24'h000000, 3'b110},
      '{656, 0, 24'h000000, 3'b010},
      '{751, 0, 24'h000000, 3'b010},
      '{752, 0, 24'h000000, 3'b110},
      '{799, 0, 24'h000000, 3'b110},
      '{255, 2, 24'hFF02FF, 3'b111},
      '{100, 3, 24'h6403FF, 3'b111}
    };
    rst = '{1'b1, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = '{1'b0, 1'b0, 1'b0};
    foreach (tbl[j]) begin
      wait_n((tbl[j].v * 800 + tbl[j].h + 1) * 2);
      check($sformatf("tbl%0d.rgb", j), int'({u[2].vr, u[2].vg, u[2].vb}), int'(tbl[j].rgb));
      check($sformatf("tbl%0d.sync", j), int'({u[2].hs, u[2].vs, u[2].bn}), int'(tbl[j].sync));
    end
    wait_n(4001 * 2 - 1);
    check("l5.before", int'({u[2].bn, u[2].vr, u[2].vg, u[2].vb}), 0);
    wait_n(4001 * 2);
    check("l5.first", int'({u[2].bn, u[2].vr, u[2].vg, u[2].vb}), 32'h10005FF);
    lo = 0; vis = 0; first = -1; hmax = 0;
    for (int k = 4801; k <= 5600; k++) begin
      wait_n(k * 2);
      if (!u[2].hs) begin
        lo++;
        if (first < 0) first = k - 4801;
      end
      if (u[2].bn) vis++;
      if (int'(u[2].h) > hmax) hmax = int'(u[2].h);
    end
    check("l6.hs_low", lo, 96);
    check("l6.hs_first", first, 656);
    check("l6.blank_hi", vis, 640);
    check("l6.hmax", hmax, 799);
    for (int g = 0; g < 4000 && u[2].h != 10'd300; g++) @(negedge clk);
    check("mid.h", int'(u[2].h), 300);
    rst = '{1'b1, 1'b1, 1'b1};
    repeat (3) begin
      @(negedge clk);
      check_reset_state("mid");
    end
    rst = '{1'b0, 1'b0, 1'b0};
    nfs = 0; n1 = 0; n2 = 0; hmax = 0; vmax = 0;
    for (int g = 0; g < 3000 && u[1].n < 2 * 780 + 20; g++) begin
      @(negedge clk);
      if (u[1].fs) begin
        nfs++;
        if (nfs == 1) n1 = u[1].n;
        else if (nfs == 2) n2 = u[1].n;
      end
      if (int'(u[1].h) > hmax) hmax = int'(u[1].h);
      if (int'(u[1].v) > vmax) vmax = int'(u[1].v);
    end
    check("div4.fs_count", nfs, 2);
    check("div4.fs_first", n1, 779);
    check("div4.fs_period", n2 - n1, 780);
    check("div4.hmax", hmax, 14);
    check("div4.vmax", vmax, 12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
